or1k_multi_ticktimer: RTL

OR1K_MULTI_TICKTIMER -- requirements
Module: or1k_multi_ticktimer

---
 rtl/or1k_tt_pkg.sv | 25 ++
 rtl/or1k_tt_channel.sv | 99 +++++++++
 rtl/or1k_multi_ticktimer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/or1k_tt_pkg.sv
// rtl/or1k_tt_pkg.sv - shared definitions for the multi-channel tick timer
//
// Purpose: TTMR field positions, timer mode encodings, the TTPSC SPR offset
// and the channel-count ceiling. Imported by or1k_tt_channel and
// or1k_multi_ticktimer.
// Ports: none (package).

package or1k_tt_pkg;

  typedef enum logic [1:0] {
    TT_MODE_DIS     = 2'b00,
    TT_MODE_RESTART = 2'b01,
    TT_MODE_ONESHOT = 2'b10,
    TT_MODE_FREE    = 2'b11
  } tt_mode_t;

  localparam int TT_MODE_HI = 31;
  localparam int TT_MODE_LO = 30;
  localparam int TT_IE_BIT  = 29;
  localparam int TT_IP_BIT  = 28;

  localparam logic [4:0] TT_PSC_OFFSET = 5'h10;
  localparam int         TT_MAX_NCH    = 8;

endpackage

// File: rtl/or1k_tt_channel.sv
// rtl/or1k_tt_channel.sv - one timer channel: TTMR/TTCR pair, match and IP logic
//
// Purpose: holds MODE/IE/IP/PERIOD and the count for a single channel,
// advances the count on shared ticks and raises a sticky interrupt pending.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   tick_i       shared counter-enable strobe
//   ttmr_we_i    SPR write strobe for this channel's TTMR
//   ttcr_we_i    SPR write strobe for this channel's TTCR
//   wdat_i       SPR write data
//   ttmr_o       TTMR read view (unused bits 0)
//   ttcr_o       TTCR read view (bits above CW are 0)
//   irq_o        IP & IE

module or1k_tt_channel
  import or1k_tt_pkg::*;
#(
  parameter int CW = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        ttmr_we_i,
  input  logic        ttcr_we_i,
  input  logic [31:0] wdat_i,
  output logic [31:0] ttmr_o,
  output logic [31:0] ttcr_o,
  output logic        irq_o
);

  tt_mode_t        mode_q, mode_d;
  logic            ie_q, ie_d;
  logic            ip_q, ip_d;
  logic [CW-1:0]   period_q, period_d;
  logic [CW-1:0]   count_q, count_d;

  logic match, active, hit;

  assign match  = (count_q == period_q);
  assign active = (mode_q != TT_MODE_DIS);
  // Pending-event condition: a match seen on a tick by an enabled channel.
  assign hit    = match & tick_i & active;

  always_comb begin
    mode_d   = mode_q;
    ie_d     = ie_q;
    ip_d     = ip_q | hit;
    period_d = period_q;
    count_d  = count_q;

    if (ttmr_we_i) begin
      mode_d   = tt_mode_t'(wdat_i[TT_MODE_HI:TT_MODE_LO]);
      ie_d     = wdat_i[TT_IE_BIT];
      period_d = wdat_i[CW-1:0];
      // Software can only clear IP; writing 1 keeps whatever IP would become.
      ip_d     = wdat_i[TT_IP_BIT] & (ip_q | hit);
    end

    if (ttcr_we_i) begin
      count_d = wdat_i[CW-1:0];
    end else if (hit && (mode_q == TT_MODE_RESTART)) begin
      count_d = '0;
    end else if (tick_i && active && !((mode_q == TT_MODE_ONESHOT) && match)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= TT_MODE_DIS;
      ie_q     <= 1'b0;
      ip_q     <= 1'b0;
      period_q <= '0;
      count_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      ie_q     <= ie_d;
      ip_q     <= ip_d;
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ttmr_o                        = '0;
    ttmr_o[TT_MODE_HI:TT_MODE_LO] = mode_q;
    ttmr_o[TT_IE_BIT]             = ie_q;
    ttmr_o[TT_IP_BIT]             = ip_q;
    ttmr_o[CW-1:0]                = period_q;
  end

  assign ttcr_o = 32'(count_q);
  assign irq_o  = ip_q & ie_q;

  // Bits between CW and the IP field are don't-care for narrow channels.
  logic unused_wdat;
  assign unused_wdat = ^wdat_i;

endmodule

// File: rtl/or1k_multi_ticktimer.sv
// rtl/or1k_multi_ticktimer.sv - multi-channel OR1K tick timer with SPR access
//
// Purpose: NCH independent timer channels sharing one tick strobe, SPR
// decode and read mux. Optional prescaler built when OR1K_TT_PRESCALER_EN
// is defined (TTPSC at offset 0x10); otherwise tick_o is 1 out of reset.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   spr_access_i  SPR access strobe
//   spr_we_i      write qualifier
//   spr_addr_i    SPR address (offset bits [4:0] decoded)
//   spr_dat_i     write data
//   spr_bus_ack   zero-wait acknowledge (= spr_access_i)
//   spr_dat_o     read data, 0 when not accessed
//   irq_o         per-channel interrupt
//   tick_o        shared counter-enable strobe

module or1k_multi_ticktimer
  import or1k_tt_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 28
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           spr_access_i,
  input  logic           spr_we_i,
  input  logic [15:0]    spr_addr_i,
  input  logic [31:0]    spr_dat_i,
  output logic           spr_bus_ack,
  output logic [31:0]    spr_dat_o,
  output logic [NCH-1:0] irq_o,
  output logic           tick_o
);

  logic        wr_en;
  logic        ch_space;
  logic [2:0]  ch_idx;
  logic [31:0] rd_dat;
  logic [31:0] ttmr_rd [NCH];
  logic [31:0] ttcr_rd [NCH];

  assign wr_en    = spr_access_i & spr_we_i;
  assign ch_space = ~spr_addr_i[4];
  assign ch_idx   = spr_addr_i[3:1];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic sel;
    assign sel = wr_en & ch_space & (ch_idx == 3'(g));

    or1k_tt_channel #(.CW(CW)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick_o),
      .ttmr_we_i (sel & ~spr_addr_i[0]),
      .ttcr_we_i (sel &  spr_addr_i[0]),
      .wdat_i    (spr_dat_i),
      .ttmr_o    (ttmr_rd[g]),
      .ttcr_o    (ttcr_rd[g]),
      .irq_o     (irq_o[g])
    );
  end

`ifdef OR1K_TT_PRESCALER_EN
  logic [15:0] psc_reload_q, psc_reload_d;
  logic [15:0] psc_cnt_q, psc_cnt_d;
  logic        psc_we;

  assign psc_we = wr_en & (spr_addr_i[4:0] == TT_PSC_OFFSET);

  // Down-counter: tick when it sits at 0, then reload, giving one tick
  // every RELOAD+1 cycles. A TTPSC write restarts the period immediately.
  always_comb begin
    psc_reload_d = psc_reload_q;
    psc_cnt_d    = psc_cnt_q;
    if (psc_we) begin
      psc_reload_d = spr_dat_i[15:0];
      psc_cnt_d    = spr_dat_i[15:0];
    end else if (psc_cnt_q == 16'd0) begin
      psc_cnt_d    = psc_reload_q;
    end else begin
      psc_cnt_d    = psc_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_reload_q <= 16'd0;
      psc_cnt_q    <= 16'd0;
    end else begin
      psc_reload_q <= psc_reload_d;
      psc_cnt_q    <= psc_cnt_d;
    end
  end

  assign tick_o = ~rst & (psc_cnt_q == 16'd0);
`else
  assign tick_o = ~rst;
`endif

  always_comb begin
    rd_dat = '0;
    if (ch_space) begin
      for (int n = 0; n < NCH; n++) begin
        if (ch_idx == 3'(n)) begin
          rd_dat = spr_addr_i[0] ? ttcr_rd[n] : ttmr_rd[n];
        end
      end
    end
`ifdef OR1K_TT_PRESCALER_EN
    else if (spr_addr_i[4:0] == TT_PSC_OFFSET) begin
      rd_dat = {16'h0000, psc_reload_q};
    end
`endif
  end

  assign spr_bus_ack = spr_access_i;
  assign spr_dat_o   = spr_access_i ? rd_dat : 32'h0;

  // Only the SPR offset is decoded; group/upper address bits are ignored.
  logic unused_addr;
  assign unused_addr = ^spr_addr_i[15:5];

endmodule
